// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC: FSM encoding, default format constants,
// and the accumulator sizing rule.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  // Wide enough that summing N full-width products plus the shifted bias cannot overflow.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mac_saturate.sv
// Fixed-point rescale of the accumulator: arithmetic shift by FRAC, clamp to DW bits,
// optional ReLU when NEURON_MAC_RELU_EN is defined.
module mac_saturate
  import neuron_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = 2 * DW_DEF + 4,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [AW-1:0] acc,
  output logic        [DW-1:0] res
);

  localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] shifted;
  logic        [DW-1:0] sat;

  // Shift toward minus infinity, then clamp into the signed DW range.
  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > MAX_V) begin
      sat = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat = shifted[DW-1:0];
    end
`ifdef NEURON_MAC_RELU_EN
    if (sat[DW-1]) begin
      res = {DW{1'b0}};
    end else begin
      res = sat;
    end
`else
    res = sat;
`endif
  end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: bias + sum of N products, rescaled and saturated.
// Optional ReLU on the result is enabled by defining NEURON_MAC_RELU_EN.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int N    = 8,
  parameter int FRAC = FRAC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] bias,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] w_in,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          busy
);

  localparam int AW = acc_width(DW, N);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  state_t                 state;
  logic signed [AW-1:0]   acc;
  logic        [CW-1:0]   cnt;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   bias_ext;
  logic        [DW-1:0]   res;
  logic                   accept;

  assign accept   = in_valid && in_ready;
  assign prod     = $signed(x_in) * $signed(w_in);
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(AW-DW){bias[DW-1]}}, bias} <<< FRAC;

  mac_saturate #(
    .DW   (DW),
    .AW   (AW),
    .FRAC (FRAC)
  ) u_sat (
    .acc (acc),
    .res (res)
  );

  // Evaluation FSM with accumulator, beat counter and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= {AW{1'b0}};
      cnt       <= {CW{1'b0}};
      out       <= {DW{1'b0}};
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
          if (start) begin
            state    <= ST_ACC;
            acc      <= bias_ext;
            cnt      <= {CW{1'b0}};
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_ACC: begin
          out_valid <= 1'b0;
          if (accept) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CW'(1'b1);
            if (cnt == LAST_BEAT) begin
              state    <= ST_FIN;
              in_ready <= 1'b0;
            end
          end
        end
        ST_FIN: begin
          out       <= res;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
